// File: rtl/sram_async_ctrl.sv
// sram_async_ctrl: valid/ready initiator for a single-port asynchronous SRAM (cs/oe/we strobes, shared bidirectional data bus).
// Latency: accept -> SETUP (1) -> ACCESS (WAIT_CYCLES) -> HOLD (1), read data pulses rsp_valid in HOLD; W+3 cycles per transaction.
// Backpressure: req_ready only in IDLE; a held request waits. Define SRAM_CTRL_BACK2BACK_EN to also accept in HOLD (W+2 cycles per transaction).
module sram_async_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2   // ACCESS-phase length, 1..15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic                  sram_cs,
  output logic                  sram_oe,
  output logic                  sram_we,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // ACCESS counts down from W-1 to 0; the cycle with count 0 is the last one.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic                  r_cmd_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_cs;
  logic                  r_oe;
  logic                  r_sram_we;
  logic                  r_drv;
  logic                  r_rsp_vld;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_cs_nxt;
  logic                  w_oe_nxt;
  logic                  w_we_nxt;
  logic                  w_drv_nxt;
  logic                  w_rsp_nxt;

`ifdef SRAM_CTRL_BACK2BACK_EN
  // HOLD can hand straight over to the next SETUP.
  assign w_ready = (r_state == ST_IDLE) || (r_state == ST_HOLD);
`else
  assign w_ready = (r_state == ST_IDLE);
`endif

  assign w_accept = req_valid && w_ready;
  assign w_last   = (r_cnt == 4'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, plus the strobe values that the next state requires (registered below so pins never see a comb path)
  always_comb begin
    w_state_nxt = r_state;
    w_cs_nxt    = 1'b0;
    w_oe_nxt    = 1'b0;
    w_we_nxt    = 1'b0;
    w_drv_nxt   = 1'b0;
    w_rsp_nxt   = 1'b0;

    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_last) w_state_nxt = ST_HOLD;
      ST_HOLD:   w_state_nxt = w_accept ? ST_SETUP : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_SETUP: begin
        // Entering SETUP always coincides with an accept, so the new command's direction decides the drive.
        w_cs_nxt  = 1'b1;
        w_drv_nxt = req_we;
      end
      ST_ACCESS: begin
        w_cs_nxt  = 1'b1;
        w_we_nxt  = r_cmd_we;
        w_oe_nxt  = !r_cmd_we;
        w_drv_nxt = r_cmd_we;
      end
      ST_HOLD: begin
        w_cs_nxt  = 1'b1;
        w_drv_nxt = r_cmd_we;
        w_rsp_nxt = !r_cmd_we;
      end
      default: begin
        w_cs_nxt = 1'b0;
      end
    endcase
  end

  // Capture the command only on the accepting edge; later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_we <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_cmd_we <= req_we;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  // ACCESS-phase down-counter, loaded while in SETUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (r_state == ST_SETUP) begin
      r_cnt <= CNT_LOAD;
    end else if ((r_state == ST_ACCESS) && !w_last) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Registered SRAM strobes, bus driver enable and response pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs      <= 1'b0;
      r_oe      <= 1'b0;
      r_sram_we <= 1'b0;
      r_drv     <= 1'b0;
      r_rsp_vld <= 1'b0;
    end else begin
      r_cs      <= w_cs_nxt;
      r_oe      <= w_oe_nxt;
      r_sram_we <= w_we_nxt;
      r_drv     <= w_drv_nxt;
      r_rsp_vld <= w_rsp_nxt;
    end
  end

  // Sample the bus on the edge that ends the last ACCESS cycle of a read; held until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if ((r_state == ST_ACCESS) && w_last && !r_cmd_we) begin
      r_rdata <= sram_data;
    end
  end

  assign req_ready    = w_ready;
  assign busy         = (r_state != ST_IDLE);
  assign rsp_valid    = r_rsp_vld;
  assign rsp_rdata    = r_rdata;
  assign sram_address = r_addr;
  assign sram_cs      = r_cs;
  assign sram_oe      = r_oe;
  assign sram_we      = r_sram_we;
  assign sram_data    = r_drv ? r_wdata : {DATA_WIDTH{1'bz}};

  // Pin-level invariants: strobe exclusivity, no drive under oe, strobes qualified by cs, command stable mid-transaction
  a_we_oe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(r_sram_we && r_oe));
  a_no_drv_oe:  assert property (@(posedge clk) disable iff (!rst_n) !(r_drv && r_oe));
  a_strobe_cs:  assert property (@(posedge clk) disable iff (!rst_n) (r_sram_we || r_oe) |-> r_cs);
  a_cmd_stable: assert property (@(posedge clk) disable iff (!rst_n)
                                 ((r_state == ST_ACCESS) || (r_state == ST_HOLD)) |->
                                 ($stable(r_addr) && $stable(r_wdata) && $stable(r_cmd_we)));

endmodule

// File: tb/tb_sram_async_ctrl.sv
// tb_sram_async_ctrl: three controllers (W=2, 1, 15), each with a behavioural async SRAM on its bus.
// Latency: per-cycle expectations derived from the cycle-numbered transaction timeline.
// Backpressure: requests are presented at negedges and either held or dropped after acceptance.
module tb_sram_async_ctrl;

`ifdef SRAM_CTRL_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid [3];
  logic       req_we    [3];
  logic [7:0] req_addr  [3];
  logic [7:0] req_wdata [3];
  logic       rdy       [3];
  logic       rspv      [3];
  logic [7:0] rdata     [3];
  logic       busy_o    [3];
  logic [7:0] addr_o    [3];
  logic       cs_o      [3];
  logic       oe_o      [3];
  logic       we_o      [3];
  wire  [7:0] bus0, bus1, bus2;
  logic       bus_z     [3];
  logic [7:0] bus_q     [3];

  logic [7:0] ram0 [256];
  logic [7:0] ram1 [256];
  logic [7:0] ram2 [256];

  logic [7:0] model   [3][256];
  bit         written [3][256];
  logic [7:0] last_rd [3];
  int         n_checks = 0;
  int         n_errors = 0;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t tbl [10];

  sram_async_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(rdy[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rspv[0]), .rsp_rdata(rdata[0]),
    .busy(busy_o[0]), .sram_address(addr_o[0]), .sram_cs(cs_o[0]), .sram_oe(oe_o[0]),
    .sram_we(we_o[0]), .sram_data(bus0));
  sram_async_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(rdy[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rspv[1]), .rsp_rdata(rdata[1]),
    .busy(busy_o[1]), .sram_address(addr_o[1]), .sram_cs(cs_o[1]), .sram_oe(oe_o[1]),
    .sram_we(we_o[1]), .sram_data(bus1));
  sram_async_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_CYCLES(15)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(rdy[2]), .req_we(req_we[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_valid(rspv[2]), .rsp_rdata(rdata[2]),
    .busy(busy_o[2]), .sram_address(addr_o[2]), .sram_cs(cs_o[2]), .sram_oe(oe_o[2]),
    .sram_we(we_o[2]), .sram_data(bus2));

  // Behavioural SRAMs: drive the bus under cs&oe, store on clock edges seen with cs&we
  assign bus0 = (cs_o[0] && oe_o[0] && !we_o[0]) ? ram0[addr_o[0]] : 8'bz;
  assign bus1 = (cs_o[1] && oe_o[1] && !we_o[1]) ? ram1[addr_o[1]] : 8'bz;
  assign bus2 = (cs_o[2] && oe_o[2] && !we_o[2]) ? ram2[addr_o[2]] : 8'bz;
  always @(posedge clk) if (cs_o[0] && we_o[0]) ram0[addr_o[0]] <= bus0;
  always @(posedge clk) if (cs_o[1] && we_o[1]) ram1[addr_o[1]] <= bus1;
  always @(posedge clk) if (cs_o[2] && we_o[2]) ram2[addr_o[2]] <= bus2;

  assign bus_z[0] = (bus0 === 8'bz);
  assign bus_z[1] = (bus1 === 8'bz);
  assign bus_z[2] = (bus2 === 8'bz);
  assign bus_q[0] = bus0;
  assign bus_q[1] = bus1;
  assign bus_q[2] = bus2;

  function automatic int wv(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // {ready, busy, cs, oe, we, rsp_valid, address, rsp_rdata}
  function automatic logic [21:0] obs(input int k);
    return {rdy[k], busy_o[k], cs_o[k], oe_o[k], we_o[k], rspv[k], addr_o[k], rdata[k]};
  endfunction

  // Expected pins in cycle c after the accept edge: SETUP=1, ACCESS=2..w+1, HOLD=w+2, IDLE=w+3
  function automatic logic [21:0] exp_obs(input int w, input int c, input logic we, input logic [7:0] a,
                                          input logic [7:0] rd_new, input logic [7:0] rd_old);
    logic act, hold, ready;
    act   = (c >= 2) && (c <= w + 1);
    hold  = (c == w + 2);
    ready = (c == w + 3) || (B2B && hold);
    return {ready, c <= w + 2, c <= w + 2, !we && act, we && act, !we && hold, a,
            (!we && c >= w + 2) ? rd_new : rd_old};
  endfunction

  task automatic cyc_chk(input int k, input int w, input int c, input logic we, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] rd, input logic [7:0] rd_old, input string tag);
    logic [21:0] m;
    m = (c <= w + 2) ? 22'h3fffff : 22'h3f00ff;   // address unconstrained in IDLE
    chk({tag, " pins"}, 32'(obs(k) & m), 32'(exp_obs(w, c, we, a, rd, rd_old) & m));
    if (we && c <= w + 2)
      chk({tag, " bus drive"}, 32'({bus_z[k], bus_q[k]}), 32'({1'b0, d}));
    else if (!we && c >= 2 && c <= w + 1)
      chk({tag, " bus ram"}, 32'({bus_z[k], bus_q[k]}), 32'({1'b0, rd}));
    else
      chk({tag, " bus z"}, 32'(bus_z[k]), 32'd1);
  endtask

  task automatic scramble(input int k);
    req_valid[k] = 1'b0;
    req_we[k]    = 1'($urandom);
    req_addr[k]  = 8'($urandom);
    req_wdata[k] = 8'($urandom);
  endtask

  task automatic rst_chk(input int k, input string tag);
    chk({tag, " pins"}, 32'(obs(k)), 32'(22'h200000));
    chk({tag, " bus z"}, 32'(bus_z[k]), 32'd1);
  endtask

  // One transaction from an idle controller; call at a negedge, returns at the IDLE negedge
  task automatic do_txn(input int k, input logic we, input logic [7:0] a, input logic [7:0] d, input logic [7:0] rd);
    int w;
    w = wv(k);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = d;
    @(posedge clk);
    for (int c = 1; c <= w + 3; c++) begin
      @(negedge clk);
      cyc_chk(k, w, c, we, a, d, rd, last_rd[k], $sformatf("k%0d %s@%02h c%0d", k, we ? "wr" : "rd", a, c));
      if (c == 1) scramble(k);
    end
    if (!we) last_rd[k] = rd;
  endtask

  // Two requests with req_valid held; the second command replaces the first mid-access
  task automatic b2b_pair(input int k, input logic we1, input logic [7:0] a1, input logic [7:0] d1, input logic [7:0] rd1,
                          input logic we2, input logic [7:0] a2, input logic [7:0] d2, input logic [7:0] rd2);
    int w, s2;
    logic [7:0] old2;
    w  = wv(k);
    s2 = B2B ? w + 3 : w + 4;   // cycle of the second SETUP
    old2 = we1 ? last_rd[k] : rd1;
    req_valid[k] = 1'b1; req_we[k] = we1; req_addr[k] = a1; req_wdata[k] = d1;
    @(posedge clk);
    for (int c = 1; c <= s2 + w + 2; c++) begin
      @(negedge clk);
      if (c < s2)
        cyc_chk(k, w, c, we1, a1, d1, rd1, last_rd[k], $sformatf("k%0d pairA@%02h c%0d", k, a1, c));
      else
        cyc_chk(k, w, c - s2 + 1, we2, a2, d2, rd2, old2, $sformatf("k%0d pairB@%02h c%0d", k, a2, c));
      if (c == 2) begin req_we[k] = we2; req_addr[k] = a2; req_wdata[k] = d2; end
      if (c == s2) scramble(k);
    end
    if (!we2) last_rd[k] = rd2;
    else if (!we1) last_rd[k] = rd1;
  endtask

  task automatic mwrite(input int k, input logic [7:0] a, input logic [7:0] d);
    model[k][a] = d;
    written[k][a] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b, d;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      scramble(k);
      last_rd[k] = 8'h00;
    end
    tbl[0] = '{1'b1, 8'h3C, 8'hA5, 8'h00};
    tbl[1] = '{1'b0, 8'h3C, 8'h00, 8'hA5};
    tbl[2] = '{1'b1, 8'h20, 8'h0F, 8'h00};
    tbl[3] = '{1'b1, 8'h01, 8'h11, 8'h00};
    tbl[4] = '{1'b0, 8'h01, 8'h00, 8'h11};
    tbl[5] = '{1'b0, 8'h20, 8'h00, 8'h0F};
    tbl[6] = '{1'b1, 8'h00, 8'hFF, 8'h00};
    tbl[7] = '{1'b0, 8'h00, 8'h00, 8'hFF};
    tbl[8] = '{1'b1, 8'h3C, 8'hC3, 8'h00};
    tbl[9] = '{1'b0, 8'h3C, 8'h00, 8'hC3};

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) rst_chk(k, $sformatf("k%0d in reset", k));
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_chk(k, $sformatf("k%0d after reset", k));

    // Directed table on the W=2 controller
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].we) mwrite(0, tbl[i].addr, tbl[i].wdata);
      do_txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
    end

    // Reset during the ACCESS phase of a write: dropped, old RAM contents survive
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h01; req_wdata[0] = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    scramble(0);
    @(negedge clk);
    chk("mid-write we before reset", 32'(we_o[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) rst_chk(k, $sformatf("k%0d async reset", k));
    @(negedge clk);
    rst_chk(0, "held reset");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) last_rd[k] = 8'h00;
    @(negedge clk);
    rst_chk(0, "reset released");
    do_txn(0, 1'b0, 8'h01, 8'h00, 8'h11);

    // Held requests: second one waits for ready, first keeps its captured address
    mwrite(0, 8'h10, 8'h77);
    b2b_pair(0, 1'b1, 8'h10, 8'h77, 8'h00, 1'b0, 8'h20, 8'h00, 8'h0F);
    mwrite(0, 8'h30, 8'hC3);
    b2b_pair(0, 1'b1, 8'h30, 8'hC3, 8'h00, 1'b0, 8'h30, 8'h00, 8'hC3);
    mwrite(0, 8'h44, 8'h99);
    b2b_pair(0, 1'b0, 8'h3C, 8'h00, 8'hC3, 1'b1, 8'h44, 8'h99, 8'h00);
    do_txn(0, 1'b0, 8'h44, 8'h00, 8'h99);

    // Random write/read pairs on every wait-cycle setting
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 64; p++) begin
        a = 8'($urandom);
        d = 8'($urandom);
        mwrite(k, a, d);
        b = 8'($urandom);
        if (!written[k][b]) b = a;
        if (p % 4 == 0) begin
          b2b_pair(k, 1'b1, a, d, 8'h00, 1'b0, b, 8'h00, model[k][b]);
        end else begin
          do_txn(k, 1'b1, a, d, 8'h00);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          do_txn(k, 1'b0, b, 8'h00, model[k][b]);
        end
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
